// File: rtl/mem_stage.sv
// MEM stage: branch resolve, data-memory req/ack access with timeout,
// and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        zero_in,
  input  logic [63:0] branch_in,
  input  logic [63:0] aluResult_in,
  input  logic [63:0] forwardB_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  mBuffer_in,
  input  logic [1:0]  wbBuffer_in,
  output logic        pcsrc,
  output logic [63:0] branch_target,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        mem_err,
  output logic [63:0] readData_out,
  output logic [63:0] aluResult_out,
  output logic [4:0]  rd_out,
  output logic [1:0]  wbBuffer_out
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        memop;
  logic        at_last;
  logic        tmo;
  logic [63:0] rdata_nxt;

  assign pcsrc         = mBuffer_in[2] & zero_in;
  assign branch_target = branch_in;
  assign dmem_addr     = aluResult_in;
  assign dmem_wdata    = forwardB_in;
  assign dmem_we       = mBuffer_in[0];
  assign memop         = mBuffer_in[1] | mBuffer_in[0];
  assign at_last       = (cnt == LAST);
  assign tmo           = at_last & ~dmem_ack;

  // req comes straight from state so reset kills it asynchronously
  assign dmem_req = (state == ACCESS);

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = memop;
      ACCESS:  stall = ~(dmem_ack | at_last);
      default: stall = 1'b0;
    endcase
  end

  // only a write-free access finished by a real ack returns data
  assign rdata_nxt =
    ((state == ACCESS) && dmem_ack && !mBuffer_in[0])
      ? dmem_rdata : 64'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (memop) begin
            state <= ACCESS;
            cnt   <= '0;
          end
        end
        ACCESS: begin
          if (dmem_ack || at_last) state <= IDLE;
          else cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_err <= 1'b0;
    end else if ((state == ACCESS) && tmo) begin
      mem_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData_out  <= '0;
      aluResult_out <= '0;
      rd_out        <= '0;
      wbBuffer_out  <= '0;
    end else if (stall) begin
      wbBuffer_out <= '0;
    end else begin
      wbBuffer_out  <= wbBuffer_in;
      rd_out        <= rd_in;
      aluResult_out <= aluResult_in;
      readData_out  <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized
// instructions checked against a transaction-level model.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        zero_in;
  logic [63:0] branch_in;
  logic [63:0] aluResult_in;
  logic [63:0] forwardB_in;
  logic [4:0]  rd_in;
  logic [2:0]  mBuffer_in;
  logic [1:0]  wbBuffer_in;
  logic        pcsrc;
  logic [63:0] branch_target;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        mem_err;
  logic [63:0] readData_out;
  logic [63:0] aluResult_out;
  logic [4:0]  rd_out;
  logic [1:0]  wbBuffer_out;

  int checks = 0;
  int errors = 0;

  logic        exp_err;
  logic [4:0]  prev_rd;
  logic [63:0] prev_alu;
  logic [63:0] prev_rdat;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .zero_in(zero_in), .branch_in(branch_in),
    .aluResult_in(aluResult_in),
    .forwardB_in(forwardB_in), .rd_in(rd_in),
    .mBuffer_in(mBuffer_in), .wbBuffer_in(wbBuffer_in),
    .pcsrc(pcsrc), .branch_target(branch_target),
    .stall(stall), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .mem_err(mem_err),
    .readData_out(readData_out),
    .aluResult_out(aluResult_out),
    .rd_out(rd_out), .wbBuffer_out(wbBuffer_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // Caller is at posedge+1. ackcyc: ACCESS cycle (1-based) with ack, 0 = none.
  task automatic run_instr(input logic [2:0]  m,
                           input logic [1:0]  wb,
                           input logic [63:0] alu,
                           input logic [63:0] fb,
                           input logic [4:0]  rd,
                           input logic        z,
                           input logic [63:0] br,
                           input int          ackcyc,
                           input logic        idle_ack);
    logic        memop;
    logic        timed_out;
    int          ncyc;
    logic [63:0] rdat;
    logic [63:0] exp_rd;
    memop     = m[1] | m[0];
    timed_out = !(ackcyc >= 1 && ackcyc <= TIMEOUT);
    ncyc      = timed_out ? TIMEOUT : ackcyc;
    rdat      = r64();
    mBuffer_in   = m;
    wbBuffer_in  = wb;
    aluResult_in = alu;
    forwardB_in  = fb;
    rd_in        = rd;
    zero_in      = z;
    branch_in    = br;
    dmem_ack     = idle_ack;
    dmem_rdata   = r64();
    @(negedge clk);
    chk("pcsrc", 64'(pcsrc), 64'(m[2] & z));
    chk("br_tgt", branch_target, br);
    chk("addr", dmem_addr, alu);
    chk("wdata", dmem_wdata, fb);
    chk("we", 64'(dmem_we), 64'(m[0]));
    chk("stall_idle", 64'(stall), 64'(memop));
    chk("req_idle", 64'(dmem_req), 64'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    if (memop) begin
      chk("bubble_wb", 64'(wbBuffer_out), 64'd0);
      chk("hold_rd", 64'(rd_out), 64'(prev_rd));
      chk("hold_alu", aluResult_out, prev_alu);
      chk("hold_rdat", readData_out, prev_rdat);
      for (int k = 1; k <= TIMEOUT; k++) begin
        dmem_rdata = (k == ackcyc) ? rdat : r64();
        dmem_ack   = (k == ackcyc);
        @(negedge clk);
        chk("req_acc", 64'(dmem_req), 64'd1);
        chk("stall_acc", 64'(stall), 64'(k != ncyc));
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        if (k == ncyc) break;
        chk("bubble_acc", 64'(wbBuffer_out), 64'd0);
      end
    end
    exp_rd = (memop && !m[0] && !timed_out) ? rdat : 64'd0;
    if (memop && timed_out) exp_err = 1'b1;
    chk("wb_out", 64'(wbBuffer_out), 64'(wb));
    chk("rd_out", 64'(rd_out), 64'(rd));
    chk("alu_out", aluResult_out, alu);
    chk("rdata_out", readData_out, exp_rd);
    chk("mem_err", 64'(mem_err), 64'(exp_err));
    chk("req_done", 64'(dmem_req), 64'd0);
    prev_rd   = rd;
    prev_alu  = alu;
    prev_rdat = exp_rd;
  endtask

  initial begin
    logic [2:0] mtab [5];
    logic [2:0] m;
    mtab[0] = 3'b000; mtab[1] = 3'b001; mtab[2] = 3'b010;
    mtab[3] = 3'b011; mtab[4] = 3'b100;

    rst_n = 1'b0;
    zero_in = 0; branch_in = 0; aluResult_in = 0;
    forwardB_in = 0; rd_in = 0; mBuffer_in = 0;
    wbBuffer_in = 0; dmem_ack = 0; dmem_rdata = 0;
    exp_err = 0; prev_rd = 0; prev_alu = 0; prev_rdat = 0;
    #12;
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_err", 64'(mem_err), 64'd0);
    chk("rst_wb", 64'(wbBuffer_out), 64'd0);
    chk("rst_rdat", readData_out, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op, load ack first cycle, store ack third cycle, timeout
    run_instr(3'b000, 2'b10, 64'h2A, 64'h0, 5'd5, 0, 64'h0, 0, 1'b1);
    run_instr(3'b010, 2'b11, 64'h100, 64'h0, 5'd7, 0, 64'h0, 1, 1'b0);
    run_instr(3'b001, 2'b00, 64'h200, 64'h55, 5'd0, 0, 64'h0, 3, 1'b0);
    run_instr(3'b010, 2'b11, 64'h300, 64'h0, 5'd9, 0, 64'h0, 0, 1'b0);
    // ack on the timeout boundary is a normal ack
    run_instr(3'b010, 2'b11, 64'h308, 64'h0, 5'd3, 0, 64'h0,
              TIMEOUT, 1'b0);
    run_instr(3'b100, 2'b00, 64'h0, 64'h0, 5'd1, 1, 64'hABC, 0, 1'b0);
    run_instr(3'b100, 2'b00, 64'h0, 64'h0, 5'd2, 0, 64'hDEF, 0, 1'b0);

    // reset mid-access
    mBuffer_in = 3'b010; wbBuffer_in = 2'b11; rd_in = 5'd4;
    @(posedge clk); #3;
    chk("pre_rst_req", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(dmem_req), 64'd0);
    chk("mid_rst_err", 64'(mem_err), 64'd0);
    chk("mid_rst_rd", 64'(rd_out), 64'd0);
    chk("mid_rst_alu", aluResult_out, 64'd0);
    chk("mid_rst_wb", 64'(wbBuffer_out), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_req", 64'(dmem_req), 64'd0);
    chk("post_rst_stall", 64'(stall), 64'd1);
    mBuffer_in = 3'b000; wbBuffer_in = 2'b00; rd_in = 5'd0;
    aluResult_in = 64'd0;
    exp_err = 0; prev_rd = 0; prev_alu = 0; prev_rdat = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      m = mtab[$urandom_range(0, 4)];
      run_instr(m, 2'($urandom), r64(), r64(), 5'($urandom),
                1'($urandom), r64(),
                int'($urandom_range(0, TIMEOUT + 1)),
                1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. Sits directly downstream of the EX/MEM register and consumes its outputs unchanged: zero, branch target, ALU result, forwarded store data, rd, M and WB control.
- Resolves the branch decision.
- Runs the data-memory access through a req/ack handshake with a timeout.
- Raises a pipeline stall while an access is pending.
- Contains the MEM/WB pipeline register that feeds writeback.

Parameters:
- TIMEOUT, 16: maximum cycles spent in ACCESS waiting for dmem_ack before forced completion. Legal range 1 to 255.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- zero_in  in  1  ALU zero flag from EX/MEM
- branch_in  in  64  branch target address from EX/MEM
- aluResult_in  in  64  ALU result; memory byte address for loads/stores
- forwardB_in  in  64  store data
- rd_in  in  5  destination register
- mBuffer_in  in  3  M control: [2]=Branch, [1]=MemRead, [0]=MemWrite
- wbBuffer_in  in  2  WB control: [1]=RegWrite, [0]=MemtoReg
- pcsrc  out  1  take branch
- branch_target  out  64  equals branch_in
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM while high
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  64  memory address
- dmem_wdata  out  64  memory write data
- dmem_ack  in  1  single-cycle completion pulse from memory
- dmem_rdata  in  64  read data; valid only in the cycle dmem_ack is high
- mem_err  out  1  sticky timeout flag
- readData_out  out  64  MEM/WB loaded data
- aluResult_out  out  64  MEM/WB ALU result
- rd_out  out  5  MEM/WB destination register
- wbBuffer_out  out  2  MEM/WB WB control

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - State is IDLE; timeout counter is 0.
  - mem_err, readData_out, aluResult_out, rd_out and wbBuffer_out are 0.
  - dmem_req drops to 0 immediately on reset assertion, including mid-access; the pending access is abandoned.
- Combinational outputs:
  - pcsrc = mBuffer_in[2] & zero_in.
  - branch_target = branch_in.
  - dmem_addr = aluResult_in.
  - dmem_wdata = forwardB_in.
  - dmem_we = mBuffer_in[0].
  - A memory op (memop) is mBuffer_in[1] | mBuffer_in[0].
- State IDLE:
  - dmem_req = 0.
  - If memop: stall = 1 and the next state is ACCESS, with the counter cleared.
  - Otherwise: stall = 0, the state stays IDLE, and the instruction retires into MEM/WB this cycle.
- State ACCESS:
  - dmem_req = 1, held until completion.
  - Completion is dmem_ack = 1, or the counter reaching TIMEOUT-1 in a cycle without ack.
  - On completion: stall = 0, the next state is IDLE, and the instruction retires into MEM/WB.
  - Otherwise: stall = 1 and the counter increments.
  - Ack in the same cycle as the timeout boundary counts as a normal ack; mem_err is not set.
  - Timeout: mem_err is set (sticky until reset) and readData_out is 0.
- Latency:
  - Non-memory instruction: 1 cycle through the stage.
  - Memory instruction: 2 cycles minimum when ack arrives in the first ACCESS cycle.
  - Memory instruction: at most TIMEOUT+1 cycles.
- MEM/WB register, at a rising edge where stall = 0:
  - wbBuffer_out <= wbBuffer_in; rd_out <= rd_in; aluResult_out <= aluResult_in.
  - readData_out <= dmem_rdata on a read completed by ack, else 0. Writes, non-memops and timeouts all give 0.
- MEM/WB register, at a rising edge where stall = 1:
  - wbBuffer_out <= 0, a bubble with RegWrite off.
  - rd_out, aluResult_out and readData_out hold their values.
- MemRead and MemWrite both set: treated as a write. dmem_we = 1 and readData_out = 0.
- EX/MEM inputs are held stable by upstream while stall is high. The stage does not re-sample them mid-access.
- dmem_ack while in IDLE is ignored.
- Branch with a memop bit set is not a legal encoding. pcsrc still follows the formula.

Test Plan:
- Reset mid-ACCESS: drop rst_n while dmem_req = 1 -> dmem_req = 0 at once, all MEM/WB outputs 0, state IDLE after release.
- ALU op, no memop: mBuffer_in=000, wbBuffer_in=10, aluResult_in=0x2A, rd_in=5 -> stall never high; next edge gives wbBuffer_out=10, rd_out=5, aluResult_out=0x2A, readData_out=0.
- Load with ack on the first ACCESS cycle: mBuffer_in=010, addr 0x100, dmem_rdata=0xDEADBEEF -> stall high for 1 cycle, dmem_req high for 1 cycle, then readData_out=0xDEADBEEF, wbBuffer_out=11; a bubble (wbBuffer_out=00) appears in the prior cycle.
- Store with ack after 3 cycles: mBuffer_in=001, forwardB_in=0x55 -> dmem_we=1, dmem_wdata=0x55 for 3 cycles, stall high for 3 cycles, readData_out=0.
- Timeout: TIMEOUT=4, load with no ack -> dmem_req high for exactly 4 cycles, then mem_err=1 stays high, readData_out=0, state IDLE.
- Branch: mBuffer_in=100 with zero_in=1 -> pcsrc=1 and branch_target=branch_in in the same cycle; with zero_in=0 -> pcsrc=0; stall=0 in both cases.
